// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : sum_accumulator
//  Description : Accepts a stream of 3-bit adder sums over a valid/ready
//                handshake, accumulates N_SAMPLES of them into a saturating
//                ACC_W-bit total and presents that total with a sticky
//                saturation flag on an output valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    // Sample counter only needs to reach N_SAMPLES-1; keep at least one bit.
    localparam int c_cnt_w = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_SAMPLES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_total;
    logic               r_out_ovf;

    logic               w_accept;
    logic [ACC_W:0]     w_next;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_sat;
    logic               w_ovf_next;

    // Saturating add of the incoming sum, carried out one bit wider than acc.
    always_comb begin
        w_accept   = in_valid & r_in_ready;
        w_next     = {1'b0, r_acc} + {{(ACC_W - 2){1'b0}}, in_sum};
        w_sat      = w_next[ACC_W];
        w_acc_sat  = w_sat ? {ACC_W{1'b1}} : w_next[ACC_W-1:0];
        w_ovf_next = r_ovf | w_sat;
    end

    // Accumulate / hold state machine; clear overrides accept and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            // out_total/out_ovf intentionally keep their last value.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_sat;
                        r_ovf <= w_ovf_next;
                        if (r_cnt == c_cnt_last) begin
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_total <= w_acc_sat;
                            r_out_ovf   <= w_ovf_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Restart only after the handshake; no same-cycle pass-through.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_total = r_out_total;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_accumulator
//  Description : Directed-vector bench for sum_accumulator. Instance a uses
//                the default parameters, instance b uses ACC_W=4 to reach
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [2:0] a_in_sum;
    logic [7:0] a_out_total;

    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [2:0] b_in_sum;
    logic [3:0] b_out_total;

    int n_vec = 0;
    int n_err = 0;

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (a_clear),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sum    (a_in_sum),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_total (a_out_total),
        .out_ovf   (a_out_ovf)
    );

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (b_clear),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sum    (b_in_sum),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_total (b_out_total),
        .out_ovf   (b_out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sum for exactly one edge on the chosen instance.
    task automatic send(input int which, input logic [2:0] s);
        if (which == 0) begin a_in_valid = 1'b1; a_in_sum = s; end
        else            begin b_in_valid = 1'b1; b_in_sum = s; end
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic consume(input int which);
        if (which == 0) a_out_ready = 1'b1; else b_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_clear = 0; a_in_valid = 0; a_in_sum = 0; a_out_ready = 0;
        b_clear = 0; b_in_valid = 0; b_in_sum = 0; b_out_ready = 0;
        tick();
        tick();
        chk("rst_in_ready",  32'(a_in_ready),  1);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_total", 32'(a_out_total), 0);
        chk("rst_out_ovf",   32'(a_out_ovf),   0);
        rst = 1'b0;
        tick();

        // Basic total 1+2+3+4 = 10
        send(0, 3'd1); send(0, 3'd2); send(0, 3'd3);
        chk("basic_not_yet", 32'(a_out_valid), 0);
        send(0, 3'd4);
        chk("basic_valid",    32'(a_out_valid), 1);
        chk("basic_total",    32'(a_out_total), 10);
        chk("basic_ovf",      32'(a_out_ovf),   0);
        chk("basic_in_ready", 32'(a_in_ready),  0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("basic_hold_total", 32'(a_out_total), 10);
            chk("basic_hold_valid", 32'(a_out_valid), 1);
        end
        consume(0);
        chk("basic_post_ready", 32'(a_in_ready),  1);
        chk("basic_post_valid", 32'(a_out_valid), 0);

        // Gapped 6,6,6,6 = 24
        for (int i = 0; i < 4; i++) begin
            send(0, 3'd6);
            if (i < 3) chk("gap_not_yet", 32'(a_out_valid), 0);
            tick();
        end
        chk("gap_valid", 32'(a_out_valid), 1);
        chk("gap_total", 32'(a_out_total), 24);

        // Input backpressure while holding; the stalled 5 is taken after the handshake
        a_in_valid = 1'b1; a_in_sum = 3'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", 32'(a_in_ready),  0);
            chk("bp_total",    32'(a_out_total), 24);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("bp_ready_back", 32'(a_in_ready), 1);
        tick();
        a_in_valid = 1'b0;
        send(0, 3'd1); send(0, 3'd1); send(0, 3'd1);
        chk("bp_total_next", 32'(a_out_total), 8);
        consume(0);

        // Saturation on the narrow instance: 6+6+6+0 -> 15 with ovf
        send(1, 3'd6); send(1, 3'd6); send(1, 3'd6); send(1, 3'd0);
        chk("sat_valid", 32'(b_out_valid), 1);
        chk("sat_total", 32'(b_out_total), 15);
        chk("sat_ovf",   32'(b_out_ovf),   1);
        consume(1);
        send(1, 3'd1); send(1, 3'd1); send(1, 3'd1); send(1, 3'd1);
        chk("sat_clr_total", 32'(b_out_total), 4);
        chk("sat_clr_ovf",   32'(b_out_ovf),   0);
        consume(1);

        // Clear drops the partial sum and the sum presented with it
        send(0, 3'd3); send(0, 3'd3);
        a_clear = 1'b1;
        send(0, 3'd3);
        a_clear = 1'b0;
        send(0, 3'd1); send(0, 3'd1); send(0, 3'd1);
        chk("clr_not_yet", 32'(a_out_valid), 0);
        send(0, 3'd1);
        chk("clr_total", 32'(a_out_total), 4);
        a_clear = 1'b1; a_out_ready = 1'b1;
        tick();
        a_clear = 1'b0; a_out_ready = 1'b0;
        chk("clr_hold_valid", 32'(a_out_valid), 0);
        chk("clr_hold_ready", 32'(a_in_ready),  1);
        tick(); tick();
        chk("clr_no_stale", 32'(a_out_valid), 0);

        // Async reset between edges after two accepts
        send(0, 3'd2); send(0, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready",  32'(a_in_ready),  1);
        chk("arst_out_valid", 32'(a_out_valid), 0);
        chk("arst_out_total", 32'(a_out_total), 0);
        tick();
        rst = 1'b0;
        tick();
        send(0, 3'd2); send(0, 3'd2); send(0, 3'd2);
        chk("arst_not_yet", 32'(a_out_valid), 0);
        send(0, 3'd2);
        chk("arst_total", 32'(a_out_total), 8);
        chk("arst_valid", 32'(a_out_valid), 1);
        consume(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 2-bit adder's 3-bit sum output.
- Accepts a stream of sums over a valid/ready handshake and accumulates exactly N_SAMPLES of them into a wider total.
- Presents the total, with a sticky saturation flag, on an output valid/ready handshake.
- Used to build multi-sample totals from the combinational adder without widening the adder itself.

Parameters:
- N_SAMPLES, 4, number of input sums per total; legal range 1..255.
- ACC_W, 8, width of the accumulator and out_total; minimum 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial or held total.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept in_sum this cycle.
- in_sum  input  3  adder sum, nominally 0..6; the value 7 is accepted arithmetically as-is.
- out_valid  output  1  out_total and out_ovf are valid.
- out_ready  input  1  consumer accepts out_total this cycle.
- out_total  output  ACC_W  accumulated total, saturating.
- out_ovf  output  1  saturation occurred during this total.

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_total=0, out_ovf=0. Releasing reset mid-operation restarts from an empty accumulation.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready at a rising edge.
- ACCUM, on accept:
  - next = acc + in_sum, computed at ACC_W+1 bits.
  - If next > 2^ACC_W-1: acc = 2^ACC_W-1 and ovf=1 (sticky until the total is consumed).
  - If cnt == N_SAMPLES-1: state=HOLD; out_total and out_out_ovf register the saturated result and the updated ovf. Otherwise cnt=cnt+1.
- ACCUM, no accept: all state holds.
- Latency: out_valid rises on the edge that accepts the Nth sum and is high in the following cycle.
- HOLD: out_total and out_ovf are stable while out_valid=1 and out_ready=0. On out_valid & out_ready: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0. The next input can be accepted in the cycle after the handshake; there is no same-cycle pass-through.
- in_valid while in HOLD is ignored because in_ready=0. The upstream producer must hold its data.
- clear=1 at an edge: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0.
  - clear takes priority over accept and over the output handshake in the same cycle. An in_sum presented in that cycle is dropped, and a held total is discarded even if out_ready=1.
  - out_total keeps its last value (don't-care while out_valid=0).
- N_SAMPLES=1: every accept goes straight to HOLD. Throughput is one total per 2 cycles at best.
- cnt width: clog2(N_SAMPLES) bits, minimum 1. It never exceeds N_SAMPLES-1.
- in_ready and out_valid are pure functions of state (registered, no combinational path from inputs).

Test Plan:
- Reset then basic total: defaults; send 1,2,3,4 back-to-back with out_ready=0 -> out_valid rises the cycle after the 4th accept, out_total=10, out_ovf=0, in_ready=0. Hold out_ready=0 for 5 cycles -> values stable. Pulse out_ready -> next cycle in_ready=1, out_valid=0.
- Gapped input: defaults; in_valid toggled every other cycle with sums 6,6,6,6 -> out_total=24 after the 4th accepted beat. Non-valid cycles do not advance cnt.
- Saturation: ACC_W=4, N_SAMPLES=4; send 6,6,6,0 -> acc saturates at 15 on the 3rd accept; out_total=15, out_ovf=1. Consume, then send 1,1,1,1 -> out_total=4, out_ovf=0 (flag cleared).
- Backpressure on input: after HOLD is entered, drive in_valid=1 with in_sum=5 for 3 cycles -> no accept, total unchanged. After the output handshake, that 5 is accepted as the first sample of the next total.
- Clear priority: defaults; send 3,3, then in the cycle presenting 3 assert clear -> acc=0, that sum dropped. Then 1,1,1,1 -> out_total=4. Also assert clear with out_ready=1 while in HOLD -> out_valid falls and no stale total is re-presented.
- Async reset mid-operation: assert rst between clock edges after 2 accepts -> in_ready=1, out_valid=0, out_total=0 immediately, without waiting for a clock edge. After release, 2,2,2,2 -> out_total=8.
